// File: rtl/systolic_sched.sv
//------------------------------------------------------------------------------
// Module   : systolic_sched
// Brief    : Operand skewing sequencer and result capture for systolic_4x4.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module systolic_sched #(
    parameter int DW      = 8,
    parameter int RW      = 16,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [16*DW-1:0] a_flat,
    input  logic [16*DW-1:0] b_flat,
    output logic             arr_rst,
    output logic [DW-1:0]    arr_a0,
    output logic [DW-1:0]    arr_a1,
    output logic [DW-1:0]    arr_a2,
    output logic [DW-1:0]    arr_a3,
    output logic [DW-1:0]    arr_b0,
    output logic [DW-1:0]    arr_b1,
    output logic [DW-1:0]    arr_b2,
    output logic [DW-1:0]    arr_b3,
    input  logic             arr_done,
    input  logic [16*RW-1:0] arr_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [16*RW-1:0] c_flat,
    output logic             out_err
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_PRIME = 3'd1;
    localparam logic [2:0] c_FEED  = 3'd2;
    localparam logic [2:0] c_WAIT  = 3'd3;
    localparam logic [2:0] c_OUT   = 3'd4;

    localparam logic [2:0] c_TLAST = 3'd6;
    localparam int         c_WCW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WCW-1:0] c_WLAST = c_WCW'(TIMEOUT - 1);

    logic [2:0]       r_state;
    logic [2:0]       r_t;
    logic [c_WCW-1:0] r_wcnt;
    logic [16*DW-1:0] r_a;
    logic [16*DW-1:0] r_b;
    logic [16*RW-1:0] r_c;
    logic             r_err;
    logic             r_arr_rst;
    logic [DW-1:0]    r_arr_a [4];
    logic [DW-1:0]    r_arr_b [4];

    logic [2:0]       w_state_nxt;
    logic [2:0]       w_t_nxt;
    logic [c_WCW-1:0] w_wcnt_nxt;
    logic             w_accept;
    logic             w_capture;
    logic             w_err_nxt;
    logic [DW-1:0]    w_arr_a_nxt [4];
    logic [DW-1:0]    w_arr_b_nxt [4];

    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        w_wcnt_nxt  = r_wcnt;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_err_nxt   = r_err;
        case (r_state)
            c_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = c_PRIME;
                    w_accept    = 1'b1;
                end
            end
            c_PRIME: begin
                w_state_nxt = c_FEED;
                w_t_nxt     = 3'd0;
            end
            c_FEED: begin
                if (r_t == c_TLAST) begin
                    w_state_nxt = c_WAIT;
                    w_t_nxt     = 3'd0;
                    w_wcnt_nxt  = '0;
                end else begin
                    w_t_nxt = r_t + 3'd1;
                end
            end
            c_WAIT: begin
                // A completion in the same cycle as the timeout is still a clean result.
                if (arr_done) begin
                    w_state_nxt = c_OUT;
                    w_capture   = 1'b1;
                    w_err_nxt   = 1'b0;
                end else if (r_wcnt == c_WLAST) begin
                    w_state_nxt = c_OUT;
                    w_capture   = 1'b1;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_wcnt_nxt = r_wcnt + 1'b1;
                end
            end
            c_OUT: begin
                if (out_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Streams are computed from the next state so the registered ports line up with FEED t.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_arr_a_nxt[i] = '0;
            w_arr_b_nxt[i] = '0;
        end
        if (w_state_nxt == c_FEED) begin
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < 4; k++) begin
                    if (int'(w_t_nxt) == i + k) begin
                        w_arr_a_nxt[i] = r_a[(4*i+k)*DW +: DW];
                        w_arr_b_nxt[i] = r_b[(4*k+i)*DW +: DW];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_IDLE;
            r_t       <= '0;
            r_wcnt    <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_err     <= 1'b0;
            r_arr_rst <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                r_arr_a[i] <= '0;
                r_arr_b[i] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_t       <= w_t_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_err     <= w_err_nxt;
            r_arr_rst <= (w_state_nxt == c_IDLE);
            if (w_accept) begin
                r_a <= a_flat;
                r_b <= b_flat;
            end
            if (w_capture) begin
                r_c <= arr_r;
            end
            for (int i = 0; i < 4; i++) begin
                r_arr_a[i] <= w_arr_a_nxt[i];
                r_arr_b[i] <= w_arr_b_nxt[i];
            end
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_OUT);
    assign c_flat    = r_c;
    assign out_err   = r_err;
    assign arr_rst   = r_arr_rst;
    assign arr_a0    = r_arr_a[0];
    assign arr_a1    = r_arr_a[1];
    assign arr_a2    = r_arr_a[2];
    assign arr_a3    = r_arr_a[3];
    assign arr_b0    = r_arr_b[0];
    assign arr_b1    = r_arr_b[1];
    assign arr_b2    = r_arr_b[2];
    assign arr_b3    = r_arr_b[3];

endmodule

`default_nettype wire

// File: doc/systolic_sched.md
# systolic_sched

Sequencer that sits in front of the `systolic_4x4` multiply array. It accepts a pair of 4x4 operand matrices over a valid/ready handshake and generates the skewed row/column operand streams. It controls the array reset, waits for the array's `done`, then returns the 16 results over a valid/ready handshake. This removes the hand-written per-row skewing that benches and upstream logic otherwise do.

## Interface
Parameters:
- DW, 8, operand width.
- RW, 16, result width.
- TIMEOUT, 16, maximum WAIT cycles before the result is forced out with error; minimum 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept operands.
- a_flat  in  16*DW  A[i][k] at bits [(4i+k)*DW +: DW].
- b_flat  in  16*DW  B[k][j] at bits [(4k+j)*DW +: DW].
- arr_rst  out  1  active-high reset to the array.
- arr_a0..arr_a3  out  DW each  row streams to array ports A0..A3.
- arr_b0..arr_b3  out  DW each  column streams to array ports B0..B3.
- arr_done  in  1  array completion flag.
- arr_r  in  16*RW  array outputs; r(4i+j) at bits [(4i+j)*RW +: RW].
- out_valid  out  1  result held.
- out_ready  in  1  downstream accepts result.
- c_flat  out  16*RW  captured result, same packing as arr_r.
- out_err  out  1  qualifies out_valid; 1 = timed out.

## Operation
- States:
  - IDLE: in_ready=1, arr_rst=1, streams 0.
  - PRIME: one cycle; arr_rst=0, streams 0.
  - FEED: 7 cycles; feed counter t=0..6.
  - WAIT: arr_rst=0, streams 0.
  - OUT: out_valid=1; arr_rst stays 0 so the array outputs stay stable.
- Transitions:
  - IDLE -> PRIME on in_valid&&in_ready; latch a_flat and b_flat into internal registers.
  - PRIME -> FEED.
  - FEED -> WAIT after t=6.
  - WAIT -> OUT when arr_done is sampled 1. Capture arr_r into c_flat; out_err=0.
  - WAIT -> OUT when the WAIT cycle counter reaches TIMEOUT without arr_done. Capture arr_r anyway; out_err=1.
  - OUT -> IDLE on out_valid&&out_ready.
- Skew rule, during the FEED cycle with counter t:
  - arr_a_i = A[i][t-i] if 0≤t-i≤3, else 0.
  - arr_b_j = B[t-j][j] if 0≤t-j≤3, else 0.
- All array-facing outputs are registered.
- arr_done is ignored in IDLE, PRIME and FEED; it is sampled only in WAIT.
- Latched operands are not modified after acceptance. in_valid is ignored outside IDLE.
- No arithmetic in this block. Widths are pass-through; c_flat is a registered copy of arr_r.

## Timing
- Reset values, asserted immediately on rst low:
  - state IDLE; in_ready=1; arr_rst=1; all arr_a*/arr_b* = 0.
  - out_valid=0; out_err=0; c_flat=0; counters 0.
- Reset mid-operation (any state): abort immediately. Operands and captured result are discarded and the array is re-held in reset. No out_valid is produced for the aborted job.
- Latency, counting the accept edge as E0:
  - PRIME is the cycle after E0.
  - FEED t=0..6 occupies cycles 2..8.
  - WAIT starts at cycle 9.
  - out_valid rises on the edge after arr_done is first sampled high in WAIT, i.e. cycle 10 at the earliest.
  - Timeout case: out_valid rises TIMEOUT cycles after WAIT entry.
- in_ready rises the cycle after the OUT handshake. Minimum job period is 11 cycles plus WAIT time.
- Backpressure: while out_ready=0, out_valid, c_flat and out_err are held constant indefinitely, and in_ready=0.
- arr_done already high on WAIT entry completes WAIT in exactly one cycle.
- arr_done and the timeout in the same cycle: arr_done wins, out_err=0.

## Test plan
- Nominal, behavioural array model:
  - A rows [1,2,4,5],[3,2,0,1],[4,5,0,1],[0,1,2,1].
  - B rows [4,1,0,1],[2,0,1,3],[3,1,2,2],[4,1,0,1].
  - Expect arr_a0 = 1,2,4,5,0,0,0; arr_a3 = 0,0,0,0,1,2,1; arr_b3 = 0,0,0,1,3,2,1 over FEED.
  - Expect c_flat r0=40, r15=8; out_err=0; arr_rst 1→0 exactly at PRIME.
- Timeout, TIMEOUT=16, arr_done tied 0 -> out_valid exactly 16 cycles after WAIT entry, out_err=1, c_flat equals arr_r at that edge.
- Backpressure: hold out_ready=0 for 5 cycles -> c_flat/out_valid stable, in_ready=0, a second in_valid ignored; handshake -> in_ready=1 next cycle.
- Reset pulse during FEED t=3 -> all outputs at reset values within the same cycle. A following job with new operands yields correct results and no stale out_valid.
- Back-to-back jobs with in_valid held high and out_ready=1 -> second accept one cycle after the first OUT handshake; second result independent of the first.
- arr_done held high from PRIME onward -> ignored until WAIT; out_valid at cycle 10 after accept.
